// File: rtl/nibble_add_sequencer_pkg.sv
// ============================================================================
// Module      : nibble_add_sequencer_pkg
// Description : Shared state encoding and nibble width for the nibble-serial
//               add/subtract sequencer and its 4-bit adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_add_sequencer_pkg;

   // Width of one adder slice; operands are processed this many bits per cycle
   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/nibble_slice_cin.sv
// ============================================================================
// Module      : nibble_slice_cin
// Description : 4-bit gate-level ripple-carry adder with carry-in. Also
//               exposes the carry into the top bit so the caller can form
//               the signed-overflow flag of a wider operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_slice_cin
   import nibble_add_sequencer_pkg::*;
(
   input  logic [NIB_W-1:0] a_i,
   input  logic [NIB_W-1:0] b_i,
   input  logic             cin_i,
   output logic [NIB_W-1:0] sum_o,
   output logic             cout_o,
   output logic             c3_o
);

   // c[i] is the carry into bit i; c[NIB_W] is the carry out of the slice
   logic [NIB_W:0] c;

   assign c[0] = cin_i;

   generate
      for (genvar i = 0; i < NIB_W; i++) begin : g_bit
         logic p;
         logic g;
         assign p        = a_i[i] ^ b_i[i];
         assign g        = a_i[i] & b_i[i];
         assign sum_o[i] = p ^ c[i];
         assign c[i+1]   = g | (p & c[i]);
      end
   endgenerate

   assign cout_o = c[NIB_W];
   assign c3_o   = c[NIB_W-1];

endmodule

`default_nettype wire

// File: rtl/nibble_add_sequencer.sv
// ============================================================================
// Module      : nibble_add_sequencer
// Description : Multi-cycle two's-complement add/subtract of W = 4*NIBBLES
//               bits using a single 4-bit ripple slice, least-significant
//               nibble first. Results are published only when complete.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_add_sequencer
   import nibble_add_sequencer_pkg::*;
#(
   parameter int NIBBLES = 4
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     sub,
   input  logic [NIB_W*NIBBLES-1:0] a,
   input  logic [NIB_W*NIBBLES-1:0] b,
   output logic                     busy,
   output logic                     done,
   output logic [NIB_W*NIBBLES-1:0] sum,
   output logic                     carryout,
   output logic                     overflow
);

   localparam int W     = NIB_W * NIBBLES;
   // Keep the index at least one bit wide so NIBBLES=1 still elaborates
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic [W-1:0]     opa_q;
   logic [W-1:0]     opb_q;
   logic [W-1:0]     work_q;
   logic [W-1:0]     work_d;
   logic [W-1:0]     sum_q;
   logic             carryout_q;
   logic             overflow_q;
   logic             busy_q;
   logic             done_q;

   logic [NIB_W-1:0] sl_a;
   logic [NIB_W-1:0] sl_b;
   logic [NIB_W-1:0] sl_sum;
   logic             sl_cout;
   logic             sl_c3;

   // Select the current nibble of each operand and splice the slice result
   // into the working word (so the final edge can publish the whole word)
   always_comb begin
      sl_a   = '0;
      sl_b   = '0;
      work_d = work_q;
      for (int n = 0; n < NIBBLES; n++) begin
         if (idx_q == IDX_W'(n)) begin
            sl_a                        = opa_q[n*NIB_W +: NIB_W];
            sl_b                        = opb_q[n*NIB_W +: NIB_W];
            work_d[n*NIB_W +: NIB_W]    = sl_sum;
         end
      end
   end

   nibble_slice_cin u_slice (
      .a_i    (sl_a),
      .b_i    (sl_b),
      .cin_i  (carry_q),
      .sum_o  (sl_sum),
      .cout_o (sl_cout),
      .c3_o   (sl_c3)
   );

   // Controller FSM: latch on start, one nibble per RUN edge, one-cycle DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         opa_q      <= '0;
         opb_q      <= '0;
         work_q     <= '0;
         sum_q      <= '0;
         carryout_q <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  // Subtraction is a + ~b + 1: invert B here, seed carry with 1
                  opa_q   <= a;
                  opb_q   <= sub ? ~b : b;
                  carry_q <= sub;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               work_q  <= work_d;
               carry_q <= sl_cout;
               if (idx_q == LAST_IDX) begin
                  sum_q      <= work_d;
                  carryout_q <= sl_cout;
                  overflow_q <= sl_c3 ^ sl_cout;
                  done_q     <= 1'b1;
                  state_q    <= ST_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign carryout = carryout_q;
   assign overflow = overflow_q;

endmodule

`default_nettype wire
